// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and its arbiter.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_e;

    // Requester identities as seen on grant_id.
    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_ECHO = 1'b1;

    localparam int DEF_ACK_TIMEOUT = 16;
    localparam int DEF_GAP_CYCLES  = 0;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin selector: picks the only full slot, or the one
// that did not win last time when both are full.
module rr_arb2
    import uart_sched_pkg::*;
(
    input  logic full0_i,
    input  logic full1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    // Pure combinational pick; the caller owns the last_grant register.
    always_comb begin
        gnt_valid_o = full0_i | full1_i;
        gnt_id_o    = REQ_CPU;
        if (full0_i && full1_i) begin
            gnt_id_o = ~last_grant_i;
        end else if (full1_i) begin
            gnt_id_o = REQ_ECHO;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART sender between the CPU store path and the RX echo path.
// Each source has a one-byte holding slot; slots are served round-robin and
// each launch waits for the sender's busy handshake to rise and then fall.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              tx_busy,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              grant_id,
    output logic              sched_busy,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int WCNT_W = $clog2(ACK_TIMEOUT);
    localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(ACK_TIMEOUT - 1);
    localparam logic [GCNT_W-1:0] GCNT_MAX = GCNT_W'(GAP_CYCLES - 1);

    sched_state_e        state_q;
    logic                full0_q, full1_q;
    logic [DATA_W-1:0]   hold0_q, hold1_q;
    logic                tx_en_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                grant_id_q;
    logic                last_grant_q;
    logic                err_pulse_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [GCNT_W-1:0]   gcnt_q;
    logic [CNT_W-1:0]    sent_cnt_q;
    logic [CNT_W-1:0]    err_cnt_q;

    logic                gnt_valid;
    logic                gnt_id;
    logic                launch_d;
    logic [DATA_W-1:0]   launch_data_d;

    rr_arb2 u_arb (
        .full0_i      (full0_q),
        .full1_i      (full1_q),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    assign launch_d      = (state_q == IDLE) && gnt_valid;
    assign launch_data_d = (gnt_id == REQ_ECHO) ? hold1_q : hold0_q;

    assign req0_ready = ~full0_q;
    assign req1_ready = ~full1_q;
    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_id_q;
    assign sched_busy = (state_q != IDLE);
    assign err_pulse  = err_pulse_q;
    assign sent_cnt   = sent_cnt_q;
    assign err_cnt    = err_cnt_q;

    // Slot 0 (CPU): capture on handshake, free when its byte is launched.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            full0_q <= 1'b0;
            hold0_q <= '0;
        end else if (req0_valid && !full0_q) begin
            hold0_q <= req0_data;
            full0_q <= 1'b1;
        end else if (launch_d && (gnt_id == REQ_CPU)) begin
            full0_q <= 1'b0;
        end
    end

    // Slot 1 (echo): same behaviour as slot 0.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            full1_q <= 1'b0;
            hold1_q <= '0;
        end else if (req1_valid && !full1_q) begin
            hold1_q <= req1_data;
            full1_q <= 1'b1;
        end else if (launch_d && (gnt_id == REQ_ECHO)) begin
            full1_q <= 1'b0;
        end
    end

    // Scheduler FSM: launch, wait for busy to rise (or time out), wait for
    // busy to fall, optional idle gap; all outputs registered here.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            grant_id_q   <= REQ_CPU;
            last_grant_q <= REQ_ECHO;
            err_pulse_q  <= 1'b0;
            wcnt_q       <= '0;
            gcnt_q       <= '0;
            sent_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            tx_en_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        tx_data_q    <= launch_data_d;
                        grant_id_q   <= gnt_id;
                        last_grant_q <= gnt_id;
                        tx_en_q      <= 1'b1;
                        wcnt_q       <= '0;
                        state_q      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (wcnt_q == WCNT_MAX) begin
                        err_pulse_q <= 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                        state_q <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + WCNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        sent_cnt_q <= sent_cnt_q + CNT_W'(1);
                        gcnt_q     <= '0;
                        if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gcnt_q == GCNT_MAX) begin
                        state_q <= IDLE;
                    end else begin
                        gcnt_q <= gcnt_q + GCNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: dutA uses the default (no gap),
// dutB shares the same inputs but enforces a 4-cycle gap between frames.
module tb_uart_tx_sched;

    logic        sysclk;
    logic        rstN;
    logic        req0Valid, req1Valid, txBusy;
    logic [7:0]  req0Data, req1Data;

    logic        req0Ready, req1Ready, txEn, grantId, schedBusy, errPulse;
    logic [7:0]  txData;
    logic [15:0] sentCnt, errCnt;

    logic        req0ReadyB, req1ReadyB, txEnB, grantIdB, schedBusyB, errPulseB;
    logic [7:0]  txDataB;
    logic [15:0] sentCntB, errCntB;

    int compared   = 0;
    int mismatched = 0;

    uart_tx_sched dutA (
        .sysclk(sysclk), .reset(rstN),
        .req0_valid(req0Valid), .req0_data(req0Data), .req0_ready(req0Ready),
        .req1_valid(req1Valid), .req1_data(req1Data), .req1_ready(req1Ready),
        .tx_busy(txBusy), .tx_en(txEn), .tx_data(txData), .grant_id(grantId),
        .sched_busy(schedBusy), .err_pulse(errPulse),
        .sent_cnt(sentCnt), .err_cnt(errCnt)
    );

    uart_tx_sched #(.GAP_CYCLES(4)) dutB (
        .sysclk(sysclk), .reset(rstN),
        .req0_valid(req0Valid), .req0_data(req0Data), .req0_ready(req0ReadyB),
        .req1_valid(req1Valid), .req1_data(req1Data), .req1_ready(req1ReadyB),
        .tx_busy(txBusy), .tx_en(txEnB), .tx_data(txDataB), .grant_id(grantIdB),
        .sched_busy(schedBusyB), .err_pulse(errPulseB),
        .sent_cnt(sentCntB), .err_cnt(errCntB)
    );

    // 10-unit system clock.
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic doReset;
        rstN = 1'b0;
        req0Valid = 1'b0; req1Valid = 1'b0;
        req0Data = 8'h00; req1Data = 8'h00;
        txBusy = 1'b0;
        tick; tick;
        rstN = 1'b1;
        tick;
    endtask

    // Holds busy for n sampled edges, then drops it for the completion edge.
    task automatic sendFrame(input int n);
        txBusy = 1'b1;
        repeat (n) tick;
        txBusy = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        doReset;
        compared++; if (txEn !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tx_en: got %b want 0", txEn); end
        compared++; if (txData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_tx_data: got %h want 00", txData); end
        compared++; if (grantId !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_grant_id: got %b want 0", grantId); end
        compared++; if (schedBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sched_busy: got %b want 0", schedBusy); end
        compared++; if (errPulse !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err_pulse: got %b want 0", errPulse); end
        compared++; if (sentCnt !== 16'd0 || errCnt !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", sentCnt, errCnt); end
        compared++; if (req0Ready !== 1'b1 || req1Ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b%b want 11", req0Ready, req1Ready); end
        compared++; if (txEnB !== 1'b0 || schedBusyB !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_gapdut: got en=%b busy=%b want 0/0", txEnB, schedBusyB); end
    endtask

    task automatic test_single_byte;
        logic sawEn;
        doReset;
        req0Valid = 1'b1; req0Data = 8'h24;
        tick;                       // accept edge
        req0Valid = 1'b0;
        compared++; if (req0Ready !== 1'b0 || txEn !== 1'b0) begin mismatched++; $display("[TB] FAIL single_accept: got ready=%b en=%b want 0/0", req0Ready, txEn); end
        tick;                       // launch edge
        compared++; if (txEn !== 1'b1) begin mismatched++; $display("[TB] FAIL single_tx_en: got %b want 1", txEn); end
        compared++; if (txData !== 8'h24) begin mismatched++; $display("[TB] FAIL single_tx_data: got %h want 24", txData); end
        compared++; if (grantId !== 1'b0 || req0Ready !== 1'b1) begin mismatched++; $display("[TB] FAIL single_grant: got gid=%b ready=%b want 0/1", grantId, req0Ready); end
        txBusy = 1'b1;
        sawEn = 1'b0;
        repeat (20) begin
            tick;
            if (txEn !== 1'b0) sawEn = 1'b1;
        end
        compared++; if (sawEn !== 1'b0) begin mismatched++; $display("[TB] FAIL single_en_width: got extra tx_en want single pulse"); end
        txBusy = 1'b0;
        compared++; if (sentCnt !== 16'd0 || schedBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_in_flight: got cnt=%0d busy=%b want 0/1", sentCnt, schedBusy); end
        tick;
        compared++; if (sentCnt !== 16'd1 || schedBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_done: got cnt=%0d busy=%b want 1/0", sentCnt, schedBusy); end
    endtask

    task automatic test_simultaneous;
        doReset;
        req0Valid = 1'b1; req0Data = 8'h24;
        req1Valid = 1'b1; req1Data = 8'h30;
        tick;
        req0Valid = 1'b0; req1Valid = 1'b0;
        tick;
        compared++; if (txEn !== 1'b1 || txData !== 8'h24 || grantId !== 1'b0) begin mismatched++; $display("[TB] FAIL simul_first: got en=%b data=%h gid=%b want 1/24/0", txEn, txData, grantId); end
        compared++; if (req1Ready !== 1'b0) begin mismatched++; $display("[TB] FAIL simul_slot1_held: got %b want 0", req1Ready); end
        txBusy = 1'b1;
        repeat (5) tick;
        txBusy = 1'b0;
        tick;                       // busy sampled low
        compared++; if (txEn !== 1'b0 || sentCnt !== 16'd1) begin mismatched++; $display("[TB] FAIL simul_between: got en=%b cnt=%0d want 0/1", txEn, sentCnt); end
        tick;                       // one cycle later: second launch
        compared++; if (txEn !== 1'b1 || txData !== 8'h30 || grantId !== 1'b1) begin mismatched++; $display("[TB] FAIL simul_second: got en=%b data=%h gid=%b want 1/30/1", txEn, txData, grantId); end
        sendFrame(3);
        compared++; if (sentCnt !== 16'd2 || schedBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL simul_done: got cnt=%0d busy=%b want 2/0", sentCnt, schedBusy); end
    endtask

    task automatic test_streaming;
        logic [7:0] d0, d1, exp0, exp1;
        logic       expGid, acc0, acc1, rdy;
        int         frames, busyLeft;
        doReset;
        d0 = 8'h10; d1 = 8'h80; exp0 = 8'h10; exp1 = 8'h80;
        expGid = 1'b0; frames = 0; busyLeft = 0;
        req0Valid = 1'b1; req0Data = d0;
        req1Valid = 1'b1; req1Data = d1;
        for (int cyc = 0; cyc < 300 && frames < 6; cyc++) begin
            acc0 = req0Ready;
            acc1 = req1Ready;
            tick;
            if (acc0) begin d0 = d0 + 8'd1; req0Data = d0; end
            if (acc1) begin d1 = d1 + 8'd1; req1Data = d1; end
            if (busyLeft > 0) begin
                busyLeft--;
                if (busyLeft == 0) txBusy = 1'b0;
            end
            if (txEn === 1'b1) begin
                compared++; if (grantId !== expGid) begin mismatched++; $display("[TB] FAIL stream_grant%0d: got %b want %b", frames, grantId, expGid); end
                compared++; if (txData !== (expGid ? exp1 : exp0)) begin mismatched++; $display("[TB] FAIL stream_data%0d: got %h want %h", frames, txData, expGid ? exp1 : exp0); end
                rdy = expGid ? req1Ready : req0Ready;
                compared++; if (rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_ready%0d: got %b want 1", frames, rdy); end
                if (expGid) exp1 = exp1 + 8'd1; else exp0 = exp0 + 8'd1;
                expGid = ~expGid;
                frames++;
                txBusy = 1'b1;
                busyLeft = 4;
            end
        end
        compared++; if (frames != 6) begin mismatched++; $display("[TB] FAIL stream_frames: got %0d want 6", frames); end
        req0Valid = 1'b0; req1Valid = 1'b0; txBusy = 1'b0;
    endtask

    task automatic test_ack_timeout;
        int errAt;
        doReset;
        req1Valid = 1'b1; req1Data = 8'h55;
        tick;
        req1Valid = 1'b0;
        tick;
        compared++; if (txEn !== 1'b1 || txData !== 8'h55 || grantId !== 1'b1) begin mismatched++; $display("[TB] FAIL ack_launch: got en=%b data=%h gid=%b want 1/55/1", txEn, txData, grantId); end
        errAt = -1;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (errPulse === 1'b1) begin errAt = k; break; end
        end
        compared++; if (errAt != 16) begin mismatched++; $display("[TB] FAIL ack_err_time: got %0d want 16", errAt); end
        compared++; if (errCnt !== 16'd1 || schedBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL ack_err_state: got cnt=%0d busy=%b want 1/0", errCnt, schedBusy); end
        tick;
        compared++; if (errPulse !== 1'b0) begin mismatched++; $display("[TB] FAIL ack_err_width: got %b want 0", errPulse); end
        req0Valid = 1'b1; req0Data = 8'h24;
        tick;
        req0Valid = 1'b0;
        tick;
        compared++; if (txEn !== 1'b1 || txData !== 8'h24) begin mismatched++; $display("[TB] FAIL ack_recover_launch: got en=%b data=%h want 1/24", txEn, txData); end
        sendFrame(3);
        compared++; if (sentCnt !== 16'd1 || errCnt !== 16'd1) begin mismatched++; $display("[TB] FAIL ack_recover_counts: got sent=%0d err=%0d want 1/1", sentCnt, errCnt); end
    endtask

    task automatic test_reset_mid_frame;
        logic sawEn;
        doReset;
        req0Valid = 1'b1; req0Data = 8'h24;
        req1Valid = 1'b1; req1Data = 8'h30;
        tick;
        req1Valid = 1'b0; req0Data = 8'h25;
        tick;                       // launch 0x24
        txBusy = 1'b1;
        tick;                       // slot 0 refilled, now WAIT_DONE
        req0Valid = 1'b0;
        compared++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0 || schedBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_setup: got r0=%b r1=%b busy=%b want 0/0/1", req0Ready, req1Ready, schedBusy); end
        tick;
        rstN = 1'b0;
        #1;
        compared++; if (txData !== 8'h00 || txEn !== 1'b0 || grantId !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_outputs: got data=%h en=%b gid=%b want 00/0/0", txData, txEn, grantId); end
        compared++; if (req0Ready !== 1'b1 || req1Ready !== 1'b1 || schedBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_slots: got r0=%b r1=%b busy=%b want 1/1/0", req0Ready, req1Ready, schedBusy); end
        tick; tick;
        rstN = 1'b1;
        txBusy = 1'b0;
        sawEn = 1'b0;
        repeat (10) begin
            tick;
            if (txEn !== 1'b0) sawEn = 1'b1;
        end
        compared++; if (sawEn !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_no_launch: got a tx_en want none"); end
        req1Valid = 1'b1; req1Data = 8'h31;
        tick;
        req1Valid = 1'b0;
        tick;
        compared++; if (txEn !== 1'b1 || txData !== 8'h31 || grantId !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_new: got en=%b data=%h gid=%b want 1/31/1", txEn, txData, grantId); end
        sendFrame(2);
        compared++; if (sentCnt !== 16'd1) begin mismatched++; $display("[TB] FAIL midrst_sent: got %0d want 1", sentCnt); end
    endtask

    task automatic test_gap;
        int launchAt;
        doReset;
        req0Valid = 1'b1; req0Data = 8'h24;
        req1Valid = 1'b1; req1Data = 8'h30;
        tick;
        req0Valid = 1'b0; req1Valid = 1'b0;
        tick;
        compared++; if (txEnB !== 1'b1 || txDataB !== 8'h24) begin mismatched++; $display("[TB] FAIL gap_first: got en=%b data=%h want 1/24", txEnB, txDataB); end
        txBusy = 1'b1;
        repeat (3) tick;
        txBusy = 1'b0;
        launchAt = -1;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (txEnB === 1'b1) begin launchAt = k; break; end
        end
        // First edge seeing busy low is k=1; launch comes 5 cycles later.
        compared++; if (launchAt != 6) begin mismatched++; $display("[TB] FAIL gap_delay: got %0d want 6", launchAt); end
        compared++; if (txDataB !== 8'h30 || grantIdB !== 1'b1 || sentCntB !== 16'd1) begin mismatched++; $display("[TB] FAIL gap_second: got data=%h gid=%b cnt=%0d want 30/1/1", txDataB, grantIdB, sentCntB); end
        sendFrame(2);
    endtask

    // Runs every scenario in order, then reports.
    initial begin
        rstN = 1'b0;
        req0Valid = 1'b0; req1Valid = 1'b0;
        req0Data = 8'h00; req1Data = 8'h00;
        txBusy = 1'b0;
        test_reset;
        test_single_byte;
        test_simultaneous;
        test_streaming;
        test_ack_timeout;
        test_reset_mid_frame;
        test_gap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
